fr_normalize: RTL and testbench

Post-adder normalization and packing stage of the floating-point MAC. It sits directly downstream of the 24-bit Kogge-Stone significand adder and consumes that adder's magnitude sum, carry-out and result sign. It internally delays the operand exponent to match the adder pipeline, normalizes the significand with a leading-zero count and shift, adjusts the exponent, and packs an IEEE-754 single-precision word with overflow, underflow and zero flags. It is free-running, with no backpressure, like the adder it follows.

---
 rtl/fr_normalize.sv | 159 +++++++++++++++
 tb/tb_fr_normalize.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fr_normalize.sv
// Post-adder normalization and IEEE-754 single-precision packing stage.
// Aligns the operand exponent with the adder result, normalizes by leading-zero count and packs with flags.
module fr_normalize #(
  parameter int ADDER_LAT = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_exp,
  input  logic [23:0] in_sum,
  input  logic        in_ovf,
  input  logic        in_sign,
  output logic        out_valid,
  output logic [31:0] out_fp,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_zero
);

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(23 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic [ADDER_LAT-1:0] dl_valid_r;
  logic [7:0]           dl_exp_r [ADDER_LAT];

  logic        n1_valid_r, n1_ovf_r, n1_sign_r;
  logic [7:0]  n1_exp_r;
  logic [23:0] n1_sum_r;
  logic [4:0]  lzc_s;

  logic              n2_valid_r, n2_zero_r, n2_sign_r;
  logic signed [9:0] n2_e_r;
  logic [22:0]       n2_frac_r;
  logic              zero_s;
  logic signed [9:0] e_s;
  logic [22:0]       frac_s;

  logic [31:0] pack_fp_s;
  logic        pack_ovf_s, pack_unf_s, pack_zero_s;

  // Exponent/valid delay line matching the adder latency
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dl_valid_r <= '0;
      for (int k = 0; k < ADDER_LAT; k++) dl_exp_r[k] <= 8'd0;
    end else begin
      dl_valid_r  <= {dl_valid_r[ADDER_LAT-2:0], in_valid};
      dl_exp_r[0] <= in_exp;
      for (int k = 1; k < ADDER_LAT; k++) dl_exp_r[k] <= dl_exp_r[k-1];
    end
  end

  // N1: capture adder result in the aligned cycle
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      n1_valid_r <= 1'b0;
      n1_ovf_r   <= 1'b0;
      n1_sign_r  <= 1'b0;
      n1_exp_r   <= 8'd0;
      n1_sum_r   <= 24'd0;
    end else begin
      n1_valid_r <= dl_valid_r[ADDER_LAT-1];
      n1_ovf_r   <= in_ovf;
      n1_sign_r  <= in_sign;
      n1_exp_r   <= dl_exp_r[ADDER_LAT-1];
      n1_sum_r   <= in_sum;
    end
  end

  // N2 combinational shift and exponent adjust; ovf with sum == 0 still takes the ovf path
  always_comb begin
    lzc_s  = lzc24(n1_sum_r);
    zero_s = 1'b0;
    e_s    = signed'({2'b00, n1_exp_r});
    frac_s = 23'd0;
    if (n1_ovf_r) begin
      e_s    = e_s + 10'sd1;
      frac_s = n1_sum_r[23:1];
    end else if (n1_sum_r == 24'd0) begin
      zero_s = 1'b1;
    end else begin
      e_s    = e_s - signed'({5'b00000, lzc_s});
      frac_s = n1_sum_r[22:0] << lzc_s;
    end
  end

  // N2 register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      n2_valid_r <= 1'b0;
      n2_zero_r  <= 1'b0;
      n2_sign_r  <= 1'b0;
      n2_e_r     <= 10'sd0;
      n2_frac_r  <= 23'd0;
    end else begin
      n2_valid_r <= n1_valid_r;
      n2_zero_r  <= zero_s;
      n2_sign_r  <= n1_sign_r;
      n2_e_r     <= e_s;
      n2_frac_r  <= frac_s;
    end
  end

  // N3 pack, zero taking priority over overflow over underflow
  always_comb begin
    pack_fp_s   = {n2_sign_r, n2_e_r[7:0], n2_frac_r};
    pack_ovf_s  = 1'b0;
    pack_unf_s  = 1'b0;
    pack_zero_s = 1'b0;
    if (n2_zero_r) begin
      pack_fp_s   = 32'h0000_0000;
      pack_zero_s = 1'b1;
    end else if (n2_e_r >= 10'sd255) begin
      pack_fp_s  = {n2_sign_r, 8'hFF, 23'd0};
      pack_ovf_s = 1'b1;
    end else if (n2_e_r <= 10'sd0) begin
      pack_fp_s  = {n2_sign_r, 31'd0};
      pack_unf_s = 1'b1;
    end else begin
      pack_fp_s = {n2_sign_r, n2_e_r[7:0], n2_frac_r};
    end
  end

  // Output register; word and flags hold while no result is valid
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid     <= 1'b0;
      out_fp        <= 32'd0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_zero      <= 1'b0;
    end else begin
      out_valid <= n2_valid_r;
      if (n2_valid_r) begin
        out_fp        <= pack_fp_s;
        out_overflow  <= pack_ovf_s;
        out_underflow <= pack_unf_s;
        out_zero      <= pack_zero_s;
      end else begin
        out_fp        <= out_fp;
        out_overflow  <= out_overflow;
        out_underflow <= out_underflow;
        out_zero      <= out_zero;
      end
    end
  end

endmodule

// File: tb/tb_fr_normalize.sv
// Directed bench for fr_normalize: per-cycle schedule of launches, aligned adder results and expected outputs.
module tb_fr_normalize;
  localparam int LAT  = 8;
  localparam int PIPE = LAT + 3;
  localparam int NC   = 64;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic [7:0]  in_exp;
  logic [23:0] in_sum;
  logic        in_ovf;
  logic        in_sign;
  logic        out_valid;
  logic [31:0] out_fp;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_zero;

  fr_normalize #(.ADDER_LAT(LAT)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_exp(in_exp),
    .in_sum(in_sum), .in_ovf(in_ovf), .in_sign(in_sign), .out_valid(out_valid),
    .out_fp(out_fp), .out_overflow(out_overflow), .out_underflow(out_underflow),
    .out_zero(out_zero)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic        v_a   [NC];
  logic [7:0]  e_a   [NC];
  logic [23:0] s_a   [NC];
  logic        o_a   [NC];
  logic        g_a   [NC];
  logic [31:0] xfp_a [NC];
  logic [2:0]  xfl_a [NC];
  logic [31:0] last_fp;
  logic [2:0]  last_fl;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [34:0] model(input logic [7:0] ex, input logic [23:0] s,
                                        input logic o, input logic g);
    int          e;
    logic [23:0] m;
    if (o) begin
      e = int'(ex) + 1;
      m = {1'b1, s[23:1]};
    end else if (s == 24'd0) begin
      return {3'b001, 32'h0};
    end else begin
      e = int'(ex);
      m = s;
      while (!m[23]) begin
        m = m << 1;
        e = e - 1;
      end
    end
    if (e >= 255) return {3'b100, g, 8'hFF, 23'h0};
    if (e <= 0)   return {3'b010, g, 31'h0};
    return {3'b000, g, 8'(e), m[22:0]};
  endfunction

  task automatic clear_sched();
    for (int i = 0; i < NC; i++) begin
      v_a[i] = 1'b0; e_a[i] = 8'd0; s_a[i] = 24'd0; o_a[i] = 1'b0; g_a[i] = 1'b0;
      xfp_a[i] = 32'd0; xfl_a[i] = 3'd0;
    end
  endtask

  // flags ordered {overflow, underflow, zero}
  task automatic launch(input int c, input logic [7:0] ex, input logic [23:0] s, input logic o,
                        input logic g, input logic [31:0] xfp, input logic [2:0] xfl);
    v_a[c] = 1'b1; e_a[c] = ex; s_a[c] = s; o_a[c] = o; g_a[c] = g;
    xfp_a[c] = xfp; xfl_a[c] = xfl;
  endtask

  task automatic launch_m(input int c, input logic [7:0] ex, input logic [23:0] s,
                          input logic o, input logic g);
    logic [34:0] r;
    r = model(ex, s, o, g);
    launch(c, ex, s, o, g, r[31:0], r[34:32]);
  endtask

  task automatic run(input int ncyc, input int rst_at);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clock);
      #1;
      if (c == rst_at + 1) resetn = 1'b1;
      in_valid = v_a[c];
      in_exp   = v_a[c] ? e_a[c] : 8'($urandom);
      if (c >= LAT && v_a[c-LAT]) begin
        in_sum = s_a[c-LAT]; in_ovf = o_a[c-LAT]; in_sign = g_a[c-LAT];
      end else begin
        in_sum = 24'($urandom); in_ovf = 1'($urandom); in_sign = 1'($urandom);
      end
      if (c == rst_at) begin
        resetn = 1'b0;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_fp", out_fp, 32'd0);
        chk("rst_flags", {29'd0, out_overflow, out_underflow, out_zero}, 32'd0);
        last_fp = 32'd0;
        last_fl = 3'd0;
        for (int k = 0; k <= c; k++) if (k + PIPE >= c) v_a[k] = 1'b0;
      end
      @(negedge clock);
      if (c >= PIPE && v_a[c-PIPE]) begin
        chk("valid", {31'd0, out_valid}, 32'd1);
        chk("fp", out_fp, xfp_a[c-PIPE]);
        chk("flags", {29'd0, out_overflow, out_underflow, out_zero}, {29'd0, xfl_a[c-PIPE]});
        last_fp = xfp_a[c-PIPE];
        last_fl = xfl_a[c-PIPE];
      end else begin
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_fp", out_fp, last_fp);
        chk("hold_flags", {29'd0, out_overflow, out_underflow, out_zero}, {29'd0, last_fl});
      end
    end
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_exp = 8'd0; in_sum = 24'd0; in_ovf = 1'b0; in_sign = 1'b0;
    last_fp = 32'd0; last_fl = 3'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_fp", out_fp, 32'd0);
    chk("reset_flags", {29'd0, out_overflow, out_underflow, out_zero}, 32'd0);
    resetn = 1'b1;

    // Directed boundary vectors
    clear_sched();
    launch(0, 8'd127, 24'h800000, 1'b0, 1'b0, 32'h3F800000, 3'b000);
    launch(1, 8'd127, 24'h000001, 1'b1, 1'b0, 32'h40000000, 3'b000);
    launch(2, 8'd254, 24'h123456, 1'b1, 1'b1, 32'hFF800000, 3'b100);
    launch(3, 8'd130, 24'h000001, 1'b0, 1'b0, 32'h35800000, 3'b000);
    launch(4, 8'd5,   24'h000100, 1'b0, 1'b1, 32'h80000000, 3'b010);
    launch(5, 8'd100, 24'h000000, 1'b0, 1'b1, 32'h00000000, 3'b001);
    launch(6, 8'd127, 24'h000000, 1'b1, 1'b0, 32'h40000000, 3'b000);
    launch(7, 8'd0,   24'h800000, 1'b0, 1'b0, 32'h00000000, 3'b010);
    launch(8, 8'd254, 24'hFFFFFF, 1'b0, 1'b0, 32'h7F7FFFFF, 3'b000);
    launch(9, 8'd1,   24'h400000, 1'b0, 1'b1, 32'h80000000, 3'b010);
    launch(10, 8'd127, 24'hFFFFFF, 1'b1, 1'b0, 32'h407FFFFF, 3'b000);
    launch(13, 8'd200, 24'h0ABCDE, 1'b0, 1'b1, 32'hE22BCDE0, 3'b000);
    run(30, -1);

    // 20-item stream with a 3-cycle gap in the middle
    clear_sched();
    for (int i = 0; i < 20; i++) begin
      logic [23:0] s;
      s = 24'($urandom) >> $urandom_range(0, 23);
      launch_m((i < 10) ? i : i + 3, 8'($urandom_range(1, 254)), s,
               ($urandom_range(0, 3) == 0), 1'($urandom));
    end
    run(40, -1);

    // Reset with 5 items in flight, then one fresh item
    clear_sched();
    for (int i = 0; i < 5; i++)
      launch_m(i, 8'($urandom_range(1, 254)), 24'($urandom) | 24'h000001, 1'b0, 1'($urandom));
    launch(9, 8'd128, 24'h600000, 1'b0, 1'b0, 32'h3FC00000, 3'b000);
    run(30, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
